phas_en_bank: RTL

//  NCH-channel phase-enabled dual-rail driver bank with a built-in 4-phase power-clock sequencer.

---
 rtl/phas_pkg.sv | 43 ++++
 rtl/phas_chan_slice.sv | 72 +++++++
 rtl/phas_en_bank.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/phas_pkg.sv
// Shared types and helpers for the phase-enabled dual-rail driver bank.
package phas_pkg;

  // Externally visible power-clock phase; WAIT reports as IDLE.
  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_EVAL    = 2'd1,
    PH_HOLD    = 2'd2,
    PH_RECOVER = 2'd3
  } phase_e;

  // Internal sequencer states; WAIT is the fourth trapezoid phase.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EVAL    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_RECOVER = 3'd3,
    ST_WAIT    = 3'd4
  } state_e;

  // Default phase length and the matching tick counter width.
  // The +1 keeps the counter at least one bit wide when PHASE_TICKS=1.
  localparam int PHASE_TICKS_DEF = 4;
  localparam int TICK_W          = $clog2(PHASE_TICKS_DEF) + 1;

  // Counter width for an arbitrary phase length (same rule as TICK_W).
  function automatic int tick_width(input int ticks);
    return $clog2(ticks) + 1;
  endfunction

  // Map a sequencer state onto the reported phase code.
  function automatic phase_e state_to_phase(input state_e s);
    phase_e p;
    case (s)
      ST_EVAL:    p = PH_EVAL;
      ST_HOLD:    p = PH_HOLD;
      ST_RECOVER: p = PH_RECOVER;
      default:    p = PH_IDLE;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/phas_chan_slice.sv
// One channel of the driver bank: operand capture, rail check and the
// registered output driver. Sequencing comes entirely from the top-level
// strobes, so every channel moves on the same trapezoid.
module phas_chan_slice (
  input  logic clk,
  input  logic rst,
  input  logic capture,   // accept edge: latch operands
  input  logic drive,     // next cycle is EVAL or HOLD
  input  logic clear,     // next cycle is IDLE: drop the per-op error flag
  input  logic b,
  input  logic b_bar,
  input  logic en,
  output logic out,
  output logic rail_err,
  output logic rail_set   // rail violation seen on this capture edge
);

  logic b_cap_q, b_cap_d;
  logic en_cap_q, en_cap_d;
  logic err_q, err_d;
  logic out_q, out_d;
  logic rail_bad;

  // Both rails equal means the dual-rail pair carries no valid value.
  assign rail_bad = (b == b_bar);

  // Next-state for capture, error flag and output driver.
  always_comb begin
    b_cap_d  = b_cap_q;
    en_cap_d = en_cap_q;
    err_d    = err_q;
    out_d    = 1'b0;
    rail_set = capture & rail_bad;

    if (capture) begin
      b_cap_d  = b;
      en_cap_d = en;
      err_d    = rail_bad;
    end else if (clear) begin
      err_d = 1'b0;
    end

    // On the accept edge the capture register is still stale, so the first
    // EVAL value is formed from the live inputs being captured.
    if (drive) begin
      if (capture) begin
        out_d = ~(b ^ en) & ~rail_bad;
      end else begin
        out_d = ~(b_cap_q ^ en_cap_q) & ~err_q;
      end
    end
  end

  // Channel registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      b_cap_q  <= 1'b0;
      en_cap_q <= 1'b0;
      err_q    <= 1'b0;
      out_q    <= 1'b0;
    end else begin
      b_cap_q  <= b_cap_d;
      en_cap_q <= en_cap_d;
      err_q    <= err_d;
      out_q    <= out_d;
    end
  end

  assign out      = out_q;
  assign rail_err = err_q;

endmodule

// File: rtl/phas_en_bank.sv
// NCH-channel phase-enabled dual-rail driver bank with its own 4-phase
// power-clock sequencer (EVAL, HOLD, RECOVER, WAIT). Each channel passes
// b when en=1 and inverts it when en=0; outputs are only driven during
// EVAL and HOLD and are forced low on a rail violation.
module phas_en_bank
  import phas_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int PHASE_TICKS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [NCH-1:0]   b,
  input  logic [NCH-1:0]   b_bar,
  input  logic [NCH-1:0]   en,
  input  logic             hold_ext,
  input  logic             err_clr,
  output logic             ack,
  output logic [NCH-1:0]   out,
  output logic             out_valid,
  output logic [1:0]       phase,
  output logic [NCH-1:0]   rail_err,
  output logic             err_sticky
);

  localparam int CNT_W = tick_width(PHASE_TICKS);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(PHASE_TICKS - 1);

  // Reject meaningless configurations at elaboration.
  if (PHASE_TICKS < 1) begin : g_bad_ticks
    $error("phas_en_bank: PHASE_TICKS must be >= 1");
  end
  if (NCH < 1) begin : g_bad_nch
    $error("phas_en_bank: NCH must be >= 1");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tick_q, tick_d;
  logic             ack_q, ack_d;
  logic             out_valid_q, out_valid_d;
  phase_e           phase_q, phase_d;
  logic             sticky_q, sticky_d;

  logic             last_tick;
  logic             accept;
  logic             drive;
  logic             clear;
  logic [NCH-1:0]   rail_set;

  // A new op may start from IDLE or on the final WAIT tick, which gives
  // back-to-back ops with no idle bubble.
  assign last_tick = (tick_q == LAST_TICK);
  assign accept    = req & ((state_q == ST_IDLE) |
                            ((state_q == ST_WAIT) & last_tick));

  // Sequencer next-state and tick counter.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (accept) begin
          state_d = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (last_tick) begin
          state_d = ST_HOLD;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        // hold_ext on the final tick freezes the counter and stretches HOLD.
        if (last_tick) begin
          if (!hold_ext) begin
            state_d = ST_RECOVER;
            tick_d  = '0;
          end
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      ST_RECOVER: begin
        if (last_tick) begin
          state_d = ST_WAIT;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      ST_WAIT: begin
        if (last_tick) begin
          state_d = accept ? ST_EVAL : ST_IDLE;
          tick_d  = '0;
        end else begin
          tick_d = tick_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  // Channel strobes and registered status outputs, derived from next state
  // so every output lines up with the phase it belongs to.
  always_comb begin
    drive       = (state_d == ST_EVAL) | (state_d == ST_HOLD);
    clear       = (state_d == ST_IDLE);
    ack_d       = accept;
    out_valid_d = (state_d == ST_HOLD);
    phase_d     = state_to_phase(state_d);
    // A new violation wins over a simultaneous clear.
    sticky_d    = (|rail_set) | (sticky_q & ~err_clr);
  end

  // Sequencer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      phase_q     <= PH_IDLE;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      phase_q     <= phase_d;
      sticky_q    <= sticky_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    phas_chan_slice u_slice (
      .clk      (clk),
      .rst      (rst),
      .capture  (accept),
      .drive    (drive),
      .clear    (clear),
      .b        (b[gi]),
      .b_bar    (b_bar[gi]),
      .en       (en[gi]),
      .out      (out[gi]),
      .rail_err (rail_err[gi]),
      .rail_set (rail_set[gi])
    );
  end

  assign ack        = ack_q;
  assign out_valid  = out_valid_q;
  assign phase      = phase_q;
  assign err_sticky = sticky_q;

endmodule
